// File: rtl/i2c_reg_bank_pkg.sv
// i2c_reg_bank_pkg: register map, control/status bit positions and commit state encoding.
package i2c_reg_bank_pkg;
    localparam logic [7:0] REG_KP_L   = 8'h40;
    localparam logic [7:0] REG_KP_H   = 8'h41;
    localparam logic [7:0] REG_KI_L   = 8'h42;
    localparam logic [7:0] REG_KI_H   = 8'h43;
    localparam logic [7:0] REG_KD_L   = 8'h44;
    localparam logic [7:0] REG_KD_H   = 8'h45;
    localparam logic [7:0] REG_SP_L   = 8'h46;
    localparam logic [7:0] REG_SP_H   = 8'h47;
    localparam logic [7:0] REG_CTRL   = 8'h48;
    localparam logic [7:0] REG_STATUS = 8'h49;
    localparam logic [7:0] REG_SPD_L  = 8'h4A;
    localparam logic [7:0] REG_SPD_H  = 8'h4B;
    localparam logic [7:0] REG_SCR0   = 8'h4C;
    localparam logic [7:0] REG_LOCK   = 8'h53;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_COMMIT = 2;
    localparam int ST_PENDING = 0;
    localparam int ST_FAULT   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_EN      = 3;
    localparam logic [7:0] LOCK_KEY = 8'hA5;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
endpackage

// File: rtl/i2c_reg_bank_if.sv
// i2c_reg_bank_if: byte-level register access bus between the I2C slave and the register bank.
interface i2c_reg_bank_if;
    logic       wr_in;
    logic       rd_in;
    logic       busy_in;
    logic [7:0] idx;
    logic [7:0] wdata;
    logic [7:0] rdata;
    modport master (output wr_in, rd_in, busy_in, idx, wdata, input rdata);
    modport slave  (input wr_in, rd_in, busy_in, idx, wdata, output rdata);
endinterface

// File: rtl/i2c_reg_bank_edge.sv
// reg_bank_edge: rising-edge detector so a level request acts exactly once.
module reg_bank_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;
    always_ff @(posedge clk) q <= rst ? 1'b0 : d;
    assign rise = d & ~q;
endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C register file with shadow/active PID gains committed at a PID loop boundary.
// Define REG_BANK_WPROT_EN to make 0x53 a lock register guarding gain writes and commits.
module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter logic [7:0]  ADDR_BASE = 8'h40,
    parameter logic [7:0]  ADDR_LAST = 8'h53,
    parameter logic [15:0] KP_RST    = 16'h0100
) (
    input  logic          clk,
    input  logic          rst,
    i2c_reg_bank_if.slave bus,
    input  logic [15:0]   speed_meas,
    input  logic          fault_in,
    input  logic          pid_sync,
    output logic [15:0]   kp,
    output logic [15:0]   ki,
    output logic [15:0]   kd,
    output logic [15:0]   setpoint,
    output logic          motor_en,
    output logic          motor_dir,
    output logic          params_updated,
    output logic          err_addr
);
    logic [7:0] idx, wdata, mux, status, snap_hi;
    logic [7:0] sh [8];
    logic [7:0] scr [8];
    logic [0:0] state;
    logic wr_e, rd_e, in_rng, gain_wr, ctrl_wr, commit_wr, locked, fault_sticky;

    assign idx   = bus.idx;
    assign wdata = bus.wdata;

    reg_bank_edge u_wr_edge (.clk(clk), .rst(rst), .d(bus.wr_in), .rise(wr_e));
    reg_bank_edge u_rd_edge (.clk(clk), .rst(rst), .d(bus.rd_in), .rise(rd_e));

    assign in_rng    = idx >= ADDR_BASE && idx <= ADDR_LAST;
    assign gain_wr   = wr_e && idx >= REG_KP_L && idx <= REG_SP_H;
    assign ctrl_wr   = wr_e && idx == REG_CTRL;
    assign commit_wr = ctrl_wr && wdata[CTRL_COMMIT] && !locked;

`ifdef REG_BANK_WPROT_EN
    always_ff @(posedge clk)
        locked <= rst ? 1'b1 : (wr_e && idx == REG_LOCK) ? (wdata != LOCK_KEY) : locked;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        status             = '0;
        status[ST_PENDING] = state == PENDING;
        status[ST_FAULT]   = fault_sticky;
        status[ST_BUSY]    = bus.busy_in;
        status[ST_EN]      = motor_en;
        mux                = 8'h00;
        if (idx >= REG_KP_L && idx <= REG_SP_H) mux = sh[idx[2:0]];
        else if (idx == REG_CTRL) mux = {6'b0, motor_dir, motor_en};
        else if (idx == REG_STATUS) mux = status;
        else if (idx == REG_SPD_L) mux = speed_meas[7:0];
        else if (idx == REG_SPD_H) mux = snap_hi;
        else if (idx >= REG_SCR0 && idx <= REG_LOCK) mux = scr[idx[2:0] + 3'd4];
`ifdef REG_BANK_WPROT_EN
        if (idx == REG_LOCK) mux = {7'b0, ~locked};
`endif
    end

    // The low speed byte is served live, so only the high byte needs a snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sh[i]  <= '0;
                scr[i] <= '0;
            end
            sh[0]          <= KP_RST[7:0];
            sh[1]          <= KP_RST[15:8];
            kp             <= KP_RST;
            ki             <= '0;
            kd             <= '0;
            setpoint       <= '0;
            motor_en       <= 1'b0;
            motor_dir      <= 1'b0;
            state          <= IDLE;
            fault_sticky   <= 1'b0;
            snap_hi        <= '0;
            bus.rdata      <= '0;
            params_updated <= 1'b0;
            err_addr       <= 1'b0;
        end else begin
            bus.rdata      <= mux;
            err_addr       <= ((wr_e || rd_e) && !in_rng) ||
                              (locked && (gain_wr || (ctrl_wr && wdata[CTRL_COMMIT])));
            params_updated <= state == PENDING && pid_sync;
            if (state == PENDING && pid_sync) begin
                kp       <= {sh[1], sh[0]};
                ki       <= {sh[3], sh[2]};
                kd       <= {sh[5], sh[4]};
                setpoint <= {sh[7], sh[6]};
            end
            state <= commit_wr ? PENDING : pid_sync ? IDLE : state;
            if (gain_wr && !locked) sh[idx[2:0]] <= wdata;
            if (wr_e && idx >= REG_SCR0 && idx <= REG_LOCK) scr[idx[2:0] + 3'd4] <= wdata;
            if (ctrl_wr) motor_dir <= wdata[CTRL_DIR];
            motor_en     <= !fault_in && (ctrl_wr ? wdata[CTRL_EN] : motor_en);
            fault_sticky <= fault_in || (fault_sticky && !(rd_e && idx == REG_STATUS));
            if (rd_e && idx == REG_SPD_L) snap_hi <= speed_meas[15:8];
        end
    end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed and random stimulus checked every cycle against a byte-map model.
module tb_i2c_reg_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] speed_meas = '0;
    logic        fault_in = 1'b0;
    logic        pid_sync = 1'b0;
    logic [15:0] kp, ki, kd, setpoint;
    logic        motor_en, motor_dir, params_updated, err_addr;
    logic [7:0]  v;

    i2c_reg_bank_if bus();

    i2c_reg_bank dut (
        .clk(clk), .rst(rst), .bus(bus), .speed_meas(speed_meas), .fault_in(fault_in),
        .pid_sync(pid_sync), .kp(kp), .ki(ki), .kd(kd), .setpoint(setpoint),
        .motor_en(motor_en), .motor_dir(motor_dir), .params_updated(params_updated),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int n_tot = 0, n_pass = 0, n_fail = 0;
    bit chk_on = 0;

    logic [7:0]  mem [256];
    logic [15:0] m_act [4];
    logic [7:0]  m_snap, m_rdata;
    logic        m_en, m_dir, m_pend, m_sticky, m_locked, m_pwr, m_prd, m_upd, m_err;

`ifdef REG_BANK_WPROT_EN
    localparam bit LOCK_RST = 1'b1;
`else
    localparam bit LOCK_RST = 1'b0;
`endif

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a >= 8'h40 && a <= 8'h47) return mem[a];
        if (a == 8'h48) return {6'b0, m_dir, m_en};
        if (a == 8'h49) return {4'b0, m_en, bus.busy_in, m_sticky, m_pend};
        if (a == 8'h4A) return speed_meas[7:0];
        if (a == 8'h4B) return m_snap;
`ifdef REG_BANK_WPROT_EN
        if (a == 8'h53) return {7'b0, !m_locked};
`endif
        if (a >= 8'h4C && a <= 8'h53) return mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin : model
        logic we, re;
        logic [7:0] a;
        a  = bus.idx;
        we = bus.wr_in && !m_pwr;
        re = bus.rd_in && !m_prd;
        if (rst) begin
            foreach (mem[i]) mem[i] = 8'h00;
            mem[8'h41] = 8'h01;
            m_act = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
            {m_en, m_dir, m_pend, m_sticky, m_pwr, m_prd, m_upd, m_err} = '0;
            m_locked = LOCK_RST;
            m_snap   = 8'h00;
            m_rdata  = 8'h00;
        end else begin
            m_rdata = model_read(a);
            m_err = ((we || re) && !(a >= 8'h40 && a <= 8'h53)) ||
                    (m_locked && we && ((a >= 8'h40 && a <= 8'h47) || (a == 8'h48 && bus.wdata[2])));
            m_upd = m_pend && pid_sync;
            if (m_upd)
                for (int i = 0; i < 4; i++) m_act[i] = {mem[8'h41 + 2 * i], mem[8'h40 + 2 * i]};
            if (we && a == 8'h48 && bus.wdata[2] && !m_locked) m_pend = 1'b1;
            else if (pid_sync) m_pend = 1'b0;
            if (we && ((a >= 8'h40 && a <= 8'h47 && !m_locked) || (a >= 8'h4C && a <= 8'h53)))
                mem[a] = bus.wdata;
            if (we && a == 8'h48) m_dir = bus.wdata[1];
            m_en = fault_in ? 1'b0 : (we && a == 8'h48) ? bus.wdata[0] : m_en;
            m_sticky = fault_in || (m_sticky && !(re && a == 8'h49));
            if (re && a == 8'h4A) m_snap = speed_meas[15:8];
`ifdef REG_BANK_WPROT_EN
            if (we && a == 8'h53) m_locked = bus.wdata != 8'hA5;
`endif
            m_pwr = bus.wr_in;
            m_prd = bus.rd_in;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdata", 16'(bus.rdata), 16'(m_rdata));
            chk("kp", kp, m_act[0]);
            chk("ki", ki, m_act[1]);
            chk("kd", kd, m_act[2]);
            chk("setpoint", setpoint, m_act[3]);
            chk("motor_en", 16'(motor_en), 16'(m_en));
            chk("motor_dir", 16'(motor_dir), 16'(m_dir));
            chk("params_updated", 16'(params_updated), 16'(m_upd));
            chk("err_addr", 16'(err_addr), 16'(m_err));
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.idx = a; bus.wdata = d; bus.wr_in = 1'b1;
        @(negedge clk);
        bus.wr_in = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.idx = a; bus.rd_in = 1'b1;
        @(negedge clk);
        bus.rd_in = 1'b0;
        d = bus.rdata;
    endtask

    task automatic pulse_pid;
        @(negedge clk);
        pid_sync = 1'b1;
        @(negedge clk);
        pid_sync = 1'b0;
    endtask

    initial begin
        bus.wr_in = 1'b0; bus.rd_in = 1'b0; bus.busy_in = 1'b0; bus.idx = 8'h00; bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1;
        chk("rst_kp", kp, 16'h0100);
        chk("rst_ki", ki, 16'h0000);
        chk("rst_rdata", 16'(bus.rdata), 16'h0000);
        chk("rst_en", 16'(motor_en), 16'h0000);
`ifdef REG_BANK_WPROT_EN
        wr(8'h53, 8'hA5);
`endif
        wr(8'h40, 8'h34);
        wr(8'h41, 8'h12);
        wr(8'h48, 8'h04);
        chk("t1_kp_before_sync", kp, 16'h0100);
        rd(8'h49, v);
        chk("t1_status_pending", 16'(v), 16'h0001);
        pulse_pid;
        chk("t1_kp_commit", kp, 16'h1234);
        chk("t1_updated", 16'(params_updated), 16'h0001);
        @(negedge clk);
        chk("t1_updated_once", 16'(params_updated), 16'h0000);

        @(negedge clk);
        bus.idx = 8'h4C; bus.wdata = 8'h77; bus.wr_in = 1'b1;
        @(negedge clk);
        bus.wdata = 8'h55;
        repeat (49) @(negedge clk);
        bus.wr_in = 1'b0;
        rd(8'h4C, v);
        chk("t2_single_write", 16'(v), 16'h0077);

        speed_meas = 16'hABCD;
        rd(8'h4A, v);
        chk("t3_speed_lo", 16'(v), 16'h00CD);
        speed_meas = 16'h1111;
        rd(8'h4B, v);
        chk("t3_speed_hi", 16'(v), 16'h00AB);

        wr(8'h48, 8'h01);
        chk("t4_en_on", 16'(motor_en), 16'h0001);
        @(negedge clk); fault_in = 1'b1;
        @(negedge clk); fault_in = 1'b0;
        chk("t4_fault_stops", 16'(motor_en), 16'h0000);
        rd(8'h49, v);
        chk("t4_status_fault", 16'(v), 16'h0002);
        rd(8'h49, v);
        chk("t4_status_cleared", 16'(v), 16'h0000);
        fault_in = 1'b1;
        wr(8'h48, 8'h01);
        chk("t4_en_blocked", 16'(motor_en), 16'h0000);
        fault_in = 1'b0;

        wr(8'h60, 8'h99);
        chk("t5_err_pulse", 16'(err_addr), 16'h0001);
        @(negedge clk);
        chk("t5_err_one_cycle", 16'(err_addr), 16'h0000);
        rd(8'h60, v);
        chk("t5_oor_rdata", 16'(v), 16'h0000);

        @(negedge clk);
        bus.idx = 8'h48; bus.wdata = 8'h04; bus.wr_in = 1'b1; pid_sync = 1'b1;
        @(negedge clk);
        bus.wr_in = 1'b0; pid_sync = 1'b0;
        chk("t7_same_cycle_no_commit", 16'(params_updated), 16'h0000);
        rd(8'h49, v);
        chk("t7_still_pending", 16'(v), 16'h0003);
        pulse_pid;
        chk("t7_next_sync_commits", 16'(params_updated), 16'h0001);

`ifdef REG_BANK_WPROT_EN
        wr(8'h53, 8'h00);
        wr(8'h42, 8'h55);
        chk("t6_locked_err", 16'(err_addr), 16'h0001);
        rd(8'h42, v);
        chk("t6_shadow_kept", 16'(v), 16'h0000);
        wr(8'h53, 8'hA5);
        wr(8'h42, 8'h10);
        wr(8'h43, 8'h00);
        wr(8'h48, 8'h04);
        pulse_pid;
        chk("t6_ki_commit", ki, 16'h0010);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst         = $urandom_range(0, 599) == 0;
            bus.wr_in   = $urandom_range(0, 3) == 0;
            bus.rd_in   = $urandom_range(0, 3) == 0;
            bus.idx     = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h40 + $urandom_range(0, 19));
            bus.wdata   = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            bus.busy_in = 1'($urandom);
            pid_sync    = $urandom_range(0, 5) == 0;
            fault_in    = $urandom_range(0, 40) == 0;
            speed_meas  = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; bus.wr_in = 1'b0; bus.rd_in = 1'b0; pid_sync = 1'b0; fault_in = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
- Register file directly downstream of the I2C slave: consumes its write strobe, index and byte, and returns read bytes on its data input.
- Holds the PID gains, setpoint and motor control bits for the BLDC controller.
- Double-buffers the gains (shadow/active) so a multi-byte update applies atomically at a control-loop boundary.
- Exposes status and a tear-free snapshot of measured speed.

Parameters:
- ADDR_BASE, 8'h40, first valid index.
- ADDR_LAST, 8'h53, last valid index.
- KP_RST, 16'h0100, reset value of Kp (shadow and active).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_in  in  1  slave write level (may stay high for many cycles)
- rd_in  in  1  slave read request level
- idx  in  8  register index from slave
- wdata  in  8  write byte from slave
- rdata  out  8  read byte to slave
- busy_in  in  1  slave transaction in progress
- speed_meas  in  16  measured speed from commutation logic
- fault_in  in  1  driver fault, level
- pid_sync  in  1  one-cycle pulse at PID loop boundary
- kp, ki, kd, setpoint  out  16 each  active parameters
- motor_en, motor_dir  out  1 each  motor control
- params_updated  out  1  one-cycle pulse on commit
- err_addr  out  1  one-cycle pulse on out-of-range access

Behaviour:
- Map, little-endian byte pairs:
  - 0x40/41 Kp, 0x42/43 Ki, 0x44/45 Kd, 0x46/47 setpoint. All shadow, RW.
  - 0x48 control: bit0 en, bit1 dir, bit2 commit. Write-only effect for commit; reads return {6'b0,dir,en}.
  - 0x49 status, RO: {4'b0, motor_en, busy_in, fault_sticky, commit_pending}.
  - 0x4A/4B speed snapshot, RO.
  - 0x4C–0x53 scratch, RW.
- Write edge detect: a write executes on the rising edge of wr_in (wr_in & ~wr_q), exactly once per transaction. Writes to RO addresses are ignored silently.
- idx outside ADDR_BASE..ADDR_LAST on a write or read edge: no state change, err_addr high for 1 cycle.
- Read path: rdata is registered as mux(idx), giving 1-cycle latency from an idx change. rdata is 8'h00 for out-of-range idx.
- Speed snapshot: on the rd_in rising edge with idx==0x4A, the full speed_meas is latched into snap[15:0]. 0x4A returns the live low byte at that edge; 0x4B returns snap[15:8].
- Fault handling:
  - fault_sticky sets when fault_in=1.
  - It clears on the rd_in rising edge with idx==0x49, unless fault_in is still 1.
  - While fault_in=1, motor_en is forced 0 and writes setting en are ignored.
- motor_en and motor_dir update immediately, 1 cycle after the write edge. They are not double-buffered.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING when control is written with bit2=1.
  - PENDING -> IDLE on pid_sync: kp/ki/kd/setpoint <= shadow, params_updated pulses 1 cycle.
- Commit boundary cases:
  - pid_sync in the same cycle as the commit write is not honoured; the next pid_sync commits.
  - A shadow write in the same cycle as the commit copy: active takes the pre-write shadow value; the new byte waits for the next commit.
  - Commit written again while PENDING: stays PENDING.
- Reset values:
  - Shadow and active Kp = KP_RST; all other gains and setpoint 0.
  - motor_en=0, motor_dir=0, state IDLE, fault_sticky=0, snap=0, scratch=0.
  - rdata=0, params_updated=0, err_addr=0, wr_q=0, rd_q=0.
- Reset mid-commit discards PENDING.

Optional Feature:
- Macro REG_BANK_WPROT_EN.
- With it defined:
  - Scratch byte 0x53 is a lock register. Writing 8'hA5 unlocks and any other value locks; reset state is locked.
  - While locked, writes to 0x40–0x47 and commit requests are dropped and err_addr pulses.
  - 0x48 en/dir writes still take effect, so the motor can always be stopped.
  - Reading 0x53 returns 8'h01 when unlocked, 8'h00 when locked.
- Without it, 0x53 is plain scratch.

Decomposition:
- Shared package: register index localparams (REG_KP_L…REG_LOCK), control bit positions, status bit positions, lock key 8'hA5, commit state encoding.
- One sub-module, reg_bank_edge: rising-edge detector instanced for wr_in and rd_in. The remainder is flat.

Test Plan:
1. Write 0x40=0x34, 0x41=0x12, 0x48=0x04, then pid_sync pulse -> kp=0x1234 one cycle after pid_sync; params_updated pulses once; kp unchanged before pid_sync.
2. Hold wr_in high 50 cycles with idx=0x4C, wdata=0x77 -> exactly one write; read 0x4C -> rdata=0x77 one cycle after idx is set.
3. speed_meas=0xABCD, read 0x4A, change speed_meas to 0x1111, read 0x4B -> bytes 0xCD then 0xAB.
4. fault_in pulse while en=1 -> motor_en=0; status bit1=1; read 0x49 -> next status read bit1=0; writing en=1 during fault -> motor_en stays 0.
5. Write idx=0x60 -> err_addr 1-cycle pulse, no register changes; read 0x60 -> rdata=0x00.
6. With REG_BANK_WPROT_EN defined: write 0x42 while locked -> ki shadow unchanged, err_addr pulses; write 0x53=0xA5, then 0x42=0x10 plus commit and pid_sync -> ki=0x0010.
